// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (minuend - subtrahend - inborrow) mod 2^WIDTH
// one bit per clock, LSB first, through a single 1-bit full-subtractor stage.
// Handshake: start is accepted only when busy=0 (IDLE); while busy=1 start is
// ignored. done pulses for one cycle when diff/outborrow carry a new result,
// and diff/outborrow hold that result until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             inborrow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             outborrow,
  output logic [1:0]       dbg_state
);

  // Counter sized to hold 0..WIDTH so it never wraps inside an operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;

  assign dbg_state = state;

  // Full-subtractor stage and the next value of the result shift register.
  always_comb begin
    d        = a_sr[0] ^ b_sr[0] ^ br;
    br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    r_next   = r_sr >> 1;
    r_next[WIDTH-1] = d;
    last_bit = (cnt == LAST);
  end

  // Control FSM with registered busy/done and the result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      outborrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= minuend;
            b_sr  <= subtrahend;
            r_sr  <= '0;
            br    <= inborrow;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            // The final bit is folded in here so diff is complete on entry to DONE.
            diff      <= r_next;
            outborrow <= br_next;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 SHALL have port minuend  input  WIDTH  operand A; captured on accepted start.
REQ-006 SHALL have port subtrahend  input  WIDTH  operand B; captured on accepted start.
REQ-007 SHALL have port inborrow  input  1  initial borrow into bit 0; captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL have port diff  output  WIDTH  result, (A - B - inborrow) mod 2^WIDTH.
REQ-011 SHALL have port outborrow  output  1  final borrow out of bit WIDTH-1.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL load both operands into shift registers, load inborrow into the borrow flop, clear the bit counter, and go to SHIFT; start=0 SHALL leave it in IDLE.
REQ-014 SHIFT SHALL process one bit per cycle, LSB first, using a single 1-bit full-subtractor stage.
- d = a0 ^ b0 ^ br
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
REQ-015 Each SHIFT cycle SHALL right-shift both operand registers and shift d into the MSB of the result shift register.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; after the WIDTH-th bit it SHALL go to DONE.
REQ-017 On the SHIFT->DONE transition the block SHALL copy the result shift register into diff and the final borrow into outborrow.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-019 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-020 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH.
REQ-021 start SHALL be ignored while busy=1, with no effect on operands, counter, or outputs.
REQ-022 diff and outborrow SHALL hold their last result through IDLE and through the SHIFT cycles of the next operation, and SHALL change only on the SHIFT->DONE transition.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.
REQ-024 For WIDTH=1 the block SHALL spend exactly one cycle in SHIFT.
REQ-025 Back-to-back operation: start held high SHALL be accepted on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear busy, done, diff, outborrow, the counter, the borrow flop and all shift registers to 0.
REQ-027 rst SHALL take priority over start and over any in-progress operation.
REQ-028 After reset mid-SHIFT, no done pulse and no diff/outborrow update SHALL occur for the aborted operation.

Verification
REQ-029 WIDTH=8, A=8'd5, B=8'd3, inborrow=0 -> done high in the 9th cycle after the start edge; diff=8'h02, outborrow=0.
REQ-030 WIDTH=8, A=8'd3, B=8'd5, inborrow=0 -> diff=8'hFE, outborrow=1; 8'hFF-8'hFF with inborrow=1 -> diff=8'hFF, outborrow=1.
REQ-031 WIDTH=8, A=0, B=0, inborrow=1 -> diff=8'hFF, outborrow=1; prior diff value held stable until that done pulse.
REQ-032 start pulsed with A=8'hAA at the 3rd SHIFT cycle of an ongoing 8'd9-8'd4 operation -> ignored; result diff=8'h05, outborrow=0.
REQ-033 rst asserted at the 4th SHIFT cycle -> next cycle busy=0, diff=0, outborrow=0, and no done pulse; a fresh 8'd7-8'd7 then gives diff=8'h00, outborrow=0.
REQ-034 WIDTH=2, all 32 combinations of A, B and inborrow, with start held high -> every result matches (A-B-inborrow) mod 4 with the correct borrow, and done pulses every 4 cycles.
